// File: rtl/vp_pkg.sv
// Shared types and widths for the value-prediction recovery controller.
// Holds the FSM state enum, core widths and the fetch redirect helper.
package vp_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    SPEC,
    COMMIT,
    FLUSH,
    FIX,
    ACK_WAIT
  } vp_ctrl_state_t;

  function automatic logic [ADDR_WIDTH-1:0] vp_next_pc(
    input logic [ADDR_WIDTH-1:0] pc
  );
    return pc + ADDR_WIDTH'(4);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clr has priority, inc is ignored once at MAX.
// Ports: clk, rst (sync, high), inc, clr -> cnt, sat (cnt == MAX).
module sat_counter #(
  parameter int MAX = 8,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          sat
);

  localparam logic [CW-1:0] LMAX = CW'(MAX);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != LMAX)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign cnt = r_cnt;
  assign sat = (r_cnt == LMAX);

endmodule

// File: rtl/vp_recovery_ctrl.sv
// Pipeline-side recovery controller for the load value predictor.
// Ports: predictor handshake in, issue tracking, flush/redirect/RF-fix out.
module vp_recovery_ctrl
  import vp_pkg::*;
#(
  parameter int MAX_SPEC      = 8,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vp_lock,
  input  logic                          vp_pred_valid,
  input  logic [ADDR_WIDTH-1:0]         load_pc,
  input  logic [REG_IDX_WIDTH-1:0]      load_dst,
  input  logic                          vp_done,
  input  logic                          vp_en_recover,
  input  logic [DATA_WIDTH-1:0]         mem_data,
  input  logic                          recovery_done_ack,
  input  logic                          spec_issue,
  output logic                          checkpoint_req,
  output logic                          commit_spec,
  output logic                          flush,
  output logic                          redirect_valid,
  output logic [ADDR_WIDTH-1:0]         redirect_pc,
  output logic                          rf_fix_we,
  output logic [REG_IDX_WIDTH-1:0]      rf_fix_idx,
  output logic [DATA_WIDTH-1:0]         rf_fix_data,
  output logic                          spec_stall,
  output logic                          recovery_done,
  output logic [$clog2(MAX_SPEC+1)-1:0] spec_cnt,
  output logic                          protocol_err
);

  localparam int CW = $clog2(MAX_SPEC + 1);

  vp_ctrl_state_t r_state;

  logic [ADDR_WIDTH-1:0]    r_pc;
  logic [REG_IDX_WIDTH-1:0] r_dst;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_ckpt;
  logic                     r_commit;
  logic                     r_flush;
  logic                     r_fix_we;
  logic                     r_rdone;
  logic                     r_perr;

  logic          w_idle;
  logic          w_spec;
  logic          w_ackw;
  logic          w_accept;
  logic          w_sat;
  logic          w_inc;
  logic          w_clr;
  logic          w_err;
  logic [CW-1:0] w_cnt;

  assign w_idle   = (r_state == IDLE);
  assign w_spec   = (r_state == SPEC);
  assign w_ackw   = (r_state == ACK_WAIT);
  assign w_accept = w_idle & vp_pred_valid & vp_lock;

  // A recovering cycle does not count the younger issue: it is squashed.
  assign w_inc = w_spec & spec_issue & ~w_sat & ~vp_en_recover;
  assign w_clr = w_accept | (r_state == COMMIT) | (r_state == FLUSH);

  assign w_err = (vp_pred_valid & ~w_idle)
               | ((vp_done | vp_en_recover) & ~w_spec)
               | (recovery_done_ack & ~w_ackw);

  sat_counter #(
    .MAX (MAX_SPEC),
    .CW  (CW)
  ) u_spec_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_inc),
    .clr (w_clr),
    .cnt (w_cnt),
    .sat (w_sat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_dst    <= '0;
      r_data   <= '0;
      r_ckpt   <= 1'b0;
      r_commit <= 1'b0;
      r_flush  <= 1'b0;
      r_fix_we <= 1'b0;
      r_rdone  <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_ckpt   <= 1'b0;
      r_commit <= 1'b0;
      r_flush  <= 1'b0;
      r_fix_we <= 1'b0;
      if (w_err) r_perr <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pc    <= vp_next_pc(load_pc);
            r_dst   <= load_dst;
            r_ckpt  <= 1'b1;
            r_state <= SPEC;
          end
        end
        SPEC: begin
          if (vp_en_recover) begin
            r_data  <= mem_data;
            r_flush <= 1'b1;
            r_state <= FLUSH;
          end else if (vp_done) begin
            r_commit <= 1'b1;
            r_state  <= COMMIT;
          end
        end
        COMMIT: r_state <= IDLE;
        FLUSH: begin
          // $zero is never written.
          r_fix_we <= (r_dst != '0);
          r_state  <= FIX;
        end
        FIX: begin
          r_rdone <= 1'b1;
          r_state <= ACK_WAIT;
        end
        ACK_WAIT: begin
          if (recovery_done_ack) begin
            r_rdone <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign checkpoint_req = r_ckpt;
  assign commit_spec    = r_commit;
  assign flush          = r_flush;
  assign redirect_valid = r_flush;
  assign redirect_pc    = r_pc;
  assign rf_fix_we      = r_fix_we;
  assign rf_fix_idx     = r_dst;
  assign rf_fix_data    = r_data;
  assign spec_stall     = w_spec & w_sat;
  assign recovery_done  = r_rdone;
  assign spec_cnt       = w_cnt;
  assign protocol_err   = r_perr;

endmodule

// File: tb/tb_vp_recovery_ctrl.sv
// Scoreboard bench for vp_recovery_ctrl: directed scenarios then random traffic.
// A timeline model schedules expected pulses; a negedge monitor checks them.
module tb_vp_recovery_ctrl;

  localparam int MAX = 8;

  logic        clk = 0;
  logic        rst = 1;
  logic        vp_lock = 0, vp_pred_valid = 0;
  logic [31:0] load_pc = 0;
  logic [4:0]  load_dst = 0;
  logic        vp_done = 0, vp_en_recover = 0;
  logic [31:0] mem_data = 0;
  logic        recovery_done_ack = 0, spec_issue = 0;
  logic        checkpoint_req, commit_spec, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic        rf_fix_we;
  logic [4:0]  rf_fix_idx;
  logic [31:0] rf_fix_data;
  logic        spec_stall, recovery_done, protocol_err;
  logic [3:0]  spec_cnt;

  vp_recovery_ctrl #(.MAX_SPEC(MAX), .REG_IDX_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .vp_lock(vp_lock),
    .vp_pred_valid(vp_pred_valid), .load_pc(load_pc),
    .load_dst(load_dst), .vp_done(vp_done),
    .vp_en_recover(vp_en_recover), .mem_data(mem_data),
    .recovery_done_ack(recovery_done_ack),
    .spec_issue(spec_issue),
    .checkpoint_req(checkpoint_req),
    .commit_spec(commit_spec), .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .rf_fix_we(rf_fix_we),
    .rf_fix_idx(rf_fix_idx), .rf_fix_data(rf_fix_data),
    .spec_stall(spec_stall),
    .recovery_done(recovery_done),
    .spec_cnt(spec_cnt), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // kind bits: 3=checkpoint 2=commit 1=flush 0=rf fix
  typedef struct {
    int          cyc;
    logic [3:0]  kind;
    logic [31:0] pc;
    logic [4:0]  idx;
    logic [31:0] data;
  } ev_t;

  typedef struct {
    int   cyc;
    int   cnt;
    bit   stall;
    bit   rdone;
    bit   perr;
  } lvl_t;

  ev_t  ev_q[$];
  lvl_t lvl_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mcyc = 0;
  bit mon_en = 0;

  // Timeline model: modes are derived from the cycle numbers at which
  // predictions, commits and recoveries happen.
  bit          m_spec = 0, m_await = 0, m_perr = 0;
  int          m_free_at = 0, m_ack_from = 0, m_zero_at = -1;
  int          m_cnt = 0;
  logic [31:0] m_pc = 0;
  logic [4:0]  m_dst = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, mcyc, a, e);
    end
  endtask

  function automatic ev_t mk(input int c, input logic [3:0] k,
                             input logic [31:0] p, input logic [4:0] i,
                             input logic [31:0] d);
    ev_t e;
    e.cyc = c; e.kind = k; e.pc = p; e.idx = i; e.data = d;
    return e;
  endfunction

  task automatic step(input bit t_rst, input bit pv, input bit lk,
                      input logic [31:0] pc, input logic [4:0] dst,
                      input bit dn, input bit rc,
                      input logic [31:0] md, input bit ak,
                      input bit is);
    lvl_t l;
    bit   idle, spec, ackw;
    @(posedge clk); #1;
    rst = t_rst; vp_pred_valid = pv; vp_lock = lk;
    load_pc = pc; load_dst = dst; vp_done = dn;
    vp_en_recover = rc; mem_data = md;
    recovery_done_ack = ak; spec_issue = is;
    if (cyc == m_zero_at) m_cnt = 0;
    idle = !m_spec && !m_await && (cyc >= m_free_at);
    spec = m_spec;
    ackw = m_await && (cyc >= m_ack_from);
    l.cyc = cyc; l.cnt = m_cnt; l.stall = spec && (m_cnt == MAX);
    l.rdone = ackw; l.perr = m_perr;
    lvl_q.push_back(l);
    mon_en = 1;
    if (t_rst) begin
      while (ev_q.size() > 0 && ev_q[$].cyc > cyc) void'(ev_q.pop_back());
      m_spec = 0; m_await = 0; m_perr = 0;
      m_free_at = cyc + 1; m_zero_at = cyc + 1;
      m_pc = 0; m_dst = 0;
    end else begin
      if ((pv && !idle) || ((dn || rc) && !spec) || (ak && !ackw))
        m_perr = 1;
      if (idle && pv && lk) begin
        m_spec = 1; m_cnt = 0;
        m_pc = pc + 32'd4; m_dst = dst;
        ev_q.push_back(mk(cyc + 1, 4'b1000, 0, 0, 0));
      end else if (spec && rc) begin
        m_spec = 0; m_await = 1; m_ack_from = cyc + 3;
        m_zero_at = cyc + 2;
        ev_q.push_back(mk(cyc + 1, 4'b0010, m_pc, 0, 0));
        if (m_dst != 0) ev_q.push_back(mk(cyc + 2, 4'b0001, 0, m_dst, md));
      end else if (spec) begin
        if (is && m_cnt < MAX) m_cnt++;
        if (dn) begin
          m_spec = 0; m_free_at = cyc + 2; m_zero_at = cyc + 2;
          ev_q.push_back(mk(cyc + 1, 4'b0100, 0, 0, 0));
        end
      end else if (ackw && ak) begin
        m_await = 0; m_free_at = cyc + 1;
      end
    end
    cyc++;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      lvl_t l;
      ev_t  e;
      logic [3:0] k;
      if (lvl_q.size() == 0) begin
        chk("lvl_q_empty", 1, 0);
      end else begin
        l = lvl_q.pop_front();
        chk("lvl_cyc", mcyc, l.cyc);
        chk("spec_cnt", {28'd0, spec_cnt}, l.cnt);
        chk("spec_stall", {31'd0, spec_stall}, {31'd0, l.stall});
        chk("recovery_done", {31'd0, recovery_done}, {31'd0, l.rdone});
        chk("protocol_err", {31'd0, protocol_err}, {31'd0, l.perr});
      end
      chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, flush});
      k = {checkpoint_req, commit_spec, flush, rf_fix_we};
      if (k != 4'b0000) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_pulse", {28'd0, k}, 0);
        end else begin
          e = ev_q.pop_front();
          chk("pulse_kind", {28'd0, k}, {28'd0, e.kind});
          chk("pulse_cyc", mcyc, e.cyc);
          if (e.kind == 4'b0010) chk("redirect_pc", redirect_pc, e.pc);
          if (e.kind == 4'b0001) begin
            chk("rf_fix_idx", {27'd0, rf_fix_idx}, {27'd0, e.idx});
            chk("rf_fix_data", rf_fix_data, e.data);
          end
        end
      end else if (ev_q.size() > 0 && ev_q[0].cyc <= mcyc) begin
        e = ev_q.pop_front();
        chk("missed_pulse", 0, {28'd0, e.kind});
      end
      mcyc++;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(2);
    // match path
    step(0, 1, 1, 32'h400, 5'd8, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    nop(3);
    // mismatch path, ack after a few held cycles
    step(0, 1, 1, 32'h400, 5'd8, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    nop(5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop(2);
    // throttle
    step(0, 1, 1, 32'h1000, 5'd3, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
    nop(3);
    // done + recover + issue together
    step(0, 1, 1, 32'h2000, 5'd9, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1, 1, 32'h12345678, 0, 1);
    nop(4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop(2);
    // pc wrap and $zero destination
    step(0, 1, 1, 32'hFFFFFFFC, 5'd0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0);
    nop(4);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop(2);
    // reset while in FIX
    step(0, 1, 1, 32'h3000, 5'd5, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 1, 32'h55AA55AA, 0, 0);
    nop(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(4);
    // stray ack in IDLE
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    nop(3);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(2);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, pv, lk, dn, rc, ak, is;
      logic [31:0] pc, md;
      logic [4:0] dst;
      r  = ($urandom_range(0, 199) == 0);
      pv = ($urandom_range(0, 99) < 25);
      lk = ($urandom_range(0, 99) < 85);
      dn = ($urandom_range(0, 99) < 8);
      rc = ($urandom_range(0, 99) < 7);
      ak = ($urandom_range(0, 99) < 30);
      is = ($urandom_range(0, 99) < 65);
      pc = $urandom() & 32'hFFFFFFFC;
      md = $urandom();
      dst = 5'($urandom_range(0, 31));
      step(r, pv, lk, pc, dst, dn, rc, md, ak, is);
    end
    nop(4);
    @(negedge clk); #1;
    chk("events_left", ev_q.size(), 0);
    chk("levels_left", lvl_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
